// File: rtl/vx_prefetch_issue_pkg.sv
// vx_prefetch_issue_pkg: shared request type, widths and line helper for the prefetch issue stage
`ifndef NW_BITS
`define NW_BITS 4
`endif
package vx_prefetch_issue_pkg;
  localparam int ADDR_W = 32;
  localparam int DROP_W = 16;
  localparam int LINE_SIZE_DEF = 64;
  typedef struct packed {
    logic [`NW_BITS-1:0] wid;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   line_addr;
  } pf_req_t;
  typedef enum logic {ST_IDLE, ST_ISSUE} issue_state_t;
  function automatic int line_bits(input int line_size);
    return $clog2(line_size);
  endfunction
  function automatic int line_addr_width(input int line_size);
    return ADDR_W - $clog2(line_size);
  endfunction
endpackage

// File: rtl/vx_prefetch_issue_filter.sv
// vx_prefetch_issue_filter: flags candidates already queued or recently issued; owns the issued-line history ring.
module vx_prefetch_issue_filter
  import vx_prefetch_issue_pkg::*;
#(
  parameter int QUEUE_SIZE = 4,
  parameter int HIST_SIZE  = 4
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [ADDR_W-1:0]                   i_line,
  input  logic [QUEUE_SIZE-1:0][ADDR_W-1:0]   i_fifo_lines,
  input  logic [QUEUE_SIZE-1:0]               i_fifo_v,
  input  logic                                i_pop,
  input  logic [ADDR_W-1:0]                   i_pop_line,
  output logic                                o_dup
);
  localparam int HW = (HIST_SIZE > 1) ? $clog2(HIST_SIZE) : 1;
  logic [ADDR_W-1:0]    r_hist [HIST_SIZE];
  logic [HIST_SIZE-1:0] r_hist_v;
  logic [HW-1:0]        r_ptr;
  always_comb begin
    o_dup = 1'b0;
    for (int k = 0; k < QUEUE_SIZE; k++) o_dup = o_dup | (i_fifo_v[k] & (i_fifo_lines[k] == i_line));
    for (int k = 0; k < HIST_SIZE; k++) o_dup = o_dup | (r_hist_v[k] & (r_hist[k] == i_line));
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist_v <= '0;
      r_ptr    <= '0;
    end else if (i_pop) begin
      r_hist[r_ptr]   <= i_pop_line;
      r_hist_v[r_ptr] <= 1'b1;
      r_ptr           <= (r_ptr == HW'(HIST_SIZE - 1)) ? '0 : r_ptr + HW'(1);
    end
  end
endmodule

// File: rtl/vx_prefetch_issue.sv
// vx_prefetch_issue: line-aligns prefetch candidates, drops zero/duplicate/overflow ones and queues the rest for the dcache.
// Define PREFETCH_DEDUP_EN to build the duplicate filter and history ring.
module vx_prefetch_issue
  import vx_prefetch_issue_pkg::*;
#(
  parameter int QUEUE_SIZE = 4,
  parameter int LINE_SIZE  = LINE_SIZE_DEF,
  parameter int HIST_SIZE  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_pf_valid,
  input  logic [`NW_BITS-1:0]          i_pf_wid,
  input  logic [31:0]                  i_pf_pc,
  input  logic [31:0]                  i_pf_addr,
  output logic                         o_dcache_req_valid,
  input  logic                         i_dcache_req_ready,
  output logic [31:0]                  o_dcache_req_addr,
  output logic [`NW_BITS-1:0]          o_dcache_req_wid,
  output logic [31:0]                  o_dcache_req_pc,
  output logic [$clog2(QUEUE_SIZE):0]  o_queue_count,
  output logic [DROP_W-1:0]            o_drop_count
);
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int LB = line_bits(LINE_SIZE);
  pf_req_t           r_mem [QUEUE_SIZE];
  logic [PW:0]       r_wr, r_rd;
  logic [DROP_W-1:0] r_drop;
  issue_state_t      r_state, w_state_nxt;
  pf_req_t           w_head;
  logic [ADDR_W-1:0] w_line;
  logic [PW:0]       w_count;
  logic              w_full, w_pop, w_push, w_drop, w_dup;
  assign w_line   = i_pf_addr >> LB;
  assign w_head   = r_mem[r_rd[PW-1:0]];
  assign w_count  = r_wr - r_rd;
  assign w_full   = (r_wr ^ r_rd) == {1'b1, {PW{1'b0}}};
  assign w_pop    = o_dcache_req_valid & i_dcache_req_ready;
  assign w_push   = i_pf_valid & (|w_line) & !w_dup & (!w_full | w_pop);
  assign w_drop   = i_pf_valid & (|w_line) & !w_push;
`ifdef PREFETCH_DEDUP_EN
  logic [QUEUE_SIZE-1:0][ADDR_W-1:0] w_fifo_lines;
  logic [QUEUE_SIZE-1:0]             w_fifo_v;
  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_ent
    assign w_fifo_lines[i] = r_mem[i].line_addr;
    assign w_fifo_v[i]     = {1'b0, PW'(PW'(i) - r_rd[PW-1:0])} < w_count;
  end
  vx_prefetch_issue_filter #(.QUEUE_SIZE(QUEUE_SIZE), .HIST_SIZE(HIST_SIZE)) u_filter (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_line       (w_line),
    .i_fifo_lines (w_fifo_lines),
    .i_fifo_v     (w_fifo_v),
    .i_pop        (w_pop),
    .i_pop_line   (w_head.line_addr),
    .o_dup        (w_dup)
  );
`else
  assign w_dup = 1'b0;
`endif
  assign o_dcache_req_valid = r_state == ST_ISSUE;
  assign o_dcache_req_addr  = o_dcache_req_valid ? ADDR_W'(w_head.line_addr << LB) : '0;
  assign o_dcache_req_wid   = o_dcache_req_valid ? w_head.wid : '0;
  assign o_dcache_req_pc    = o_dcache_req_valid ? w_head.pc : '0;
  assign o_queue_count      = w_count;
  assign o_drop_count       = r_drop;
  always_comb begin
    w_state_nxt = (r_state == ST_IDLE) ? (w_push ? ST_ISSUE : ST_IDLE)
                : ((w_pop && !w_push && w_count == (PW+1)'(1)) ? ST_IDLE : ST_ISSUE);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_drop  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_wr    <= r_wr + (PW+1)'(w_push);
      r_rd    <= r_rd + (PW+1)'(w_pop);
      r_state <= w_state_nxt;
      if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[PW-1:0]] <= '{wid: i_pf_wid, pc: i_pf_pc, line_addr: w_line};
  end
endmodule

// File: tb/tb_vx_prefetch_issue.sv
// tb_vx_prefetch_issue: directed stimulus checked every cycle against a queue-based model of the prefetch issue stage.
`timescale 1ns/1ps
`ifndef NW_BITS
`define NW_BITS 4
`endif
module tb_vx_prefetch_issue;
`ifdef PREFETCH_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  localparam int QS = 4, LS = 64, HS = 4;
  typedef struct {
    int unsigned         line;
    logic [`NW_BITS-1:0] wid;
    logic [31:0]         pc;
  } ent_t;

  logic clk = 1'b0, reset = 1'b1;
  logic pf_valid = 1'b0, ready = 1'b0;
  logic [`NW_BITS-1:0] pf_wid = '0;
  logic [31:0] pf_pc = '0, pf_addr = '0;
  logic req_valid;
  logic [31:0] req_addr, req_pc;
  logic [`NW_BITS-1:0] req_wid;
  logic [2:0] qcount;
  logic [15:0] dcount;
  int checks = 0, errors = 0;

  vx_prefetch_issue #(.QUEUE_SIZE(QS), .LINE_SIZE(LS), .HIST_SIZE(HS)) dut (
    .i_clk(clk), .i_reset(reset), .i_pf_valid(pf_valid), .i_pf_wid(pf_wid), .i_pf_pc(pf_pc),
    .i_pf_addr(pf_addr), .o_dcache_req_valid(req_valid), .i_dcache_req_ready(ready),
    .o_dcache_req_addr(req_addr), .o_dcache_req_wid(req_wid), .o_dcache_req_pc(req_pc),
    .o_queue_count(qcount), .o_drop_count(dcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  ent_t q[$];
  int unsigned hist[$];
  int unsigned issued[$];
  int unsigned m_drops = 0;
  bit live = 1'b0;

  always @(posedge clk) begin : model
    int unsigned line;
    bit pop, dup, acc;
    if (reset) begin
      q.delete();
      hist.delete();
      m_drops = 0;
      live = 1'b1;
    end else if (live) begin
      line = pf_addr / LS;
      pop = (q.size() > 0) && ready;
      dup = 1'b0;
      if (DEDUP) begin
        foreach (q[k]) if (q[k].line == line) dup = 1'b1;
        foreach (hist[k]) if (hist[k] == line) dup = 1'b1;
      end
      acc = pf_valid && line != 0 && !dup && (q.size() < QS || pop);
      if (pf_valid && line != 0 && !acc && m_drops < 32'hFFFF) m_drops++;
      if (pop) begin
        hist.push_back(q[0].line);
        issued.push_back(q[0].line * LS);
        void'(q.pop_front());
        if (hist.size() > HS) void'(hist.pop_front());
      end
      if (acc) q.push_back('{line, pf_wid, pf_pc});
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("valid", {31'b0, req_valid}, {31'b0, q.size() > 0});
      chk("count", {29'b0, qcount}, q.size());
      chk("drops", {16'b0, dcount}, m_drops);
      if (q.size() > 0) begin
        chk("addr", req_addr, q[0].line * LS);
        chk("wid", 32'(req_wid), 32'(q[0].wid));
        chk("pc", req_pc, q[0].pc);
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] a, input bit r);
    @(negedge clk);
    pf_valid = v;
    pf_addr  = a;
    pf_pc    = 32'h8000_0000 | a;
    pf_wid   = `NW_BITS'(a >> 6);
    ready    = r;
  endtask

  task automatic rst(input bit r);
    @(negedge clk);
    reset = 1'b1;
    pf_valid = 1'b0;
    ready = r;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", {31'b0, req_valid}, 0);
    chk("rst_count", {29'b0, qcount}, 0);
    chk("rst_drop", {16'b0, dcount}, 0);
    chk("rst_addr", req_addr, 0);
  endtask

  initial begin
    rst(1'b0);
    // single candidate, aligned and issued once
    cyc(1, 32'h1044, 1);
    cyc(0, 0, 1);
    chk("t1_valid", {31'b0, req_valid}, 1);
    chk("t1_addr", req_addr, 32'h1040);
    cyc(0, 0, 1);
    chk("t1_empty", {29'b0, qcount}, 0);
    chk("t1_drop", {16'b0, dcount}, 0);
    // overflow while stalled, then drain in order
    rst(1'b0);
    cyc(1, 32'h100, 0);
    cyc(1, 32'h140, 0);
    cyc(1, 32'h180, 0);
    cyc(1, 32'h1C0, 0);
    cyc(1, 32'h200, 0);
    cyc(0, 0, 0);
    chk("t2_count", {29'b0, qcount}, 4);
    chk("t2_drop", {16'b0, dcount}, 1);
    chk("t2_head", req_addr, 32'h100);
    issued.delete();
    repeat (5) cyc(0, 0, 1);
    chk("t2_issued_n", issued.size(), 4);
    if (issued.size() == 4) begin
      chk("t2_iss0", issued[0], 32'h100);
      chk("t2_iss1", issued[1], 32'h140);
      chk("t2_iss2", issued[2], 32'h180);
      chk("t2_iss3", issued[3], 32'h1C0);
    end
    // same line twice, then a history hit
    rst(1'b1);
    issued.delete();
    cyc(1, 32'h2000, 1);
    cyc(1, 32'h2010, 1);
    cyc(0, 0, 1);
    cyc(1, 32'h2000, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("t3_drop", {16'b0, dcount}, DEDUP ? 2 : 0);
    chk("t3_issued_n", issued.size(), DEDUP ? 1 : 3);
    // full queue with a pop accepts a new candidate
    rst(1'b0);
    cyc(1, 32'h300, 0);
    cyc(1, 32'h340, 0);
    cyc(1, 32'h380, 0);
    cyc(1, 32'h3C0, 0);
    cyc(1, 32'h400, 1);
    cyc(0, 0, 0);
    chk("t4_count", {29'b0, qcount}, 4);
    chk("t4_drop", {16'b0, dcount}, 0);
    chk("t4_head", req_addr, 32'h340);
    // zero line is not counted; full drop is
    cyc(1, 32'h3C, 0);
    cyc(0, 0, 0);
    chk("t5_zero_drop", {16'b0, dcount}, 0);
    cyc(1, 32'h500, 0);
    cyc(0, 0, 0);
    chk("t5_full_drop", {16'b0, dcount}, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t6_count3", {29'b0, qcount}, 3);
    chk("t6_pending", {31'b0, req_valid}, 1);
    rst(1'b0);
    // mixed traffic over a few lines with intermittent ready
    for (int i = 0; i < 48; i++)
      cyc((i % 4) != 3, 32'h1000 + ((i * 7) % 5) * 64 + (i % 3) * 4, (i % 3) != 0);
    repeat (8) cyc(0, 0, 1);
    chk("drain_count", {29'b0, qcount}, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_prefetch_issue.md
# VX_prefetch_issue

Downstream stage of the Apogee prefetcher in the LSU path. Accepts at most one prefetch candidate per cycle, aligns it to a cache line and filters out duplicates. Buffers survivors in a small FIFO and issues them to the data-cache prefetch request port under a valid/ready handshake. Candidates that cannot be buffered are dropped and counted, because the prefetcher has no backpressure.

## Interface
Parameters:
- QUEUE_SIZE, 4: FIFO depth; power of two, ≥2.
- LINE_SIZE, 64: cache line bytes; power of two.
- HIST_SIZE, 4: number of recently issued line addresses remembered for dedup; ≥1.

Ports:
- clk  in  1  clock; single clock domain, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pf_valid  in  1  candidate present this cycle; no ready is returned.
- pf_wid  in  `NW_BITS  issuing warp.
- pf_pc  in  32  PC of the triggering load.
- pf_addr  in  32  byte address of the candidate.
- dcache_req_valid  out  1  prefetch request pending.
- dcache_req_ready  in  1  cache accepts the request.
- dcache_req_addr  out  32  line-aligned byte address; low log2(LINE_SIZE) bits are 0.
- dcache_req_wid  out  `NW_BITS  warp of the request.
- dcache_req_pc  out  32  PC of the request.
- queue_count  out  $clog2(QUEUE_SIZE)+1  current FIFO occupancy.
- drop_count  out  16  saturating count of dropped candidates.

## Operation
- Line address: pf_addr[31:LB], where LB = log2(LINE_SIZE). The issued address is {line, LB zeros}.
- A candidate is dropped when any of the following holds:
  - pf_valid=0.
  - Line address is 0. The prefetcher emits 0 when confidence is low. Not counted.
  - Duplicate: matches a valid FIFO entry (including the head popping this cycle) or a history entry. Counted.
  - FIFO full and no pop this cycle. Counted.
- Push condition: accepted = pf_valid & line≠0 & !dup & (!full | pop), with pop = dcache_req_valid & dcache_req_ready. Push and pop in the same cycle leave occupancy unchanged.
- On every pop, the head line address is written into the history ring. The history is round-robin and overwrites the oldest entry.
- The FIFO uses read/write pointers with one extra wrap bit. full = pointers differ only in the wrap bit; empty = pointers equal.
- dcache_req_* is driven directly from the head entry. dcache_req_valid = !empty.
- Request fields stay stable while valid & !ready.
- drop_count saturates at 16'hFFFF.
- Issue state machine:
  - IDLE (empty) → ISSUE when occupancy > 0.
  - ISSUE → IDLE when the last entry pops and there is no simultaneous push.
  - Otherwise stays in ISSUE.

## Timing
- Reset values:
  - dcache_req_valid=0, queue_count=0, drop_count=0.
  - dcache_req_addr/wid/pc=0.
  - History entries invalid; pointers 0.
- Latency: a candidate at cycle t appears on dcache_req_* at cycle t+1 at the earliest (registered FIFO, no bypass).
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: all queued entries and history are discarded on that edge, and any pending request is withdrawn in the next cycle. No partial issue.
- Dedup compares against the registered state only. Two identical candidates on consecutive cycles: the second sees the first already in the FIFO and is dropped.

## Configuration
- PREFETCH_DEDUP_EN defined: the duplicate filter and history ring are built as described.
- PREFETCH_DEDUP_EN undefined:
  - No FIFO/history comparison and no history storage.
  - Duplicates are queued and issued. Only full-drops are counted.
  - HIST_SIZE is ignored.
  - The zero-address filter remains.

## Structure
- Shared package VX_prefetch_pkg:
  - pf_req_t {wid, pc, line_addr}.
  - Constants for LINE_BITS and LINE_ADDR_WIDTH, derived from LINE_SIZE.
  - Drop-counter width (16).
- One sub-module, VX_prefetch_filter:
  - Holds the history ring.
  - Performs the parallel compare against FIFO entries and history.
  - Output: a single dup flag.
  - Instantiated only under PREFETCH_DEDUP_EN.

## Test plan
- Reset, then pf_addr=0x1044 with ready=1 → one cycle later dcache_req_addr=0x1040 is valid for one cycle; queue_count returns to 0; drop_count=0.
- ready=0, push 5 distinct lines (0x100,0x140,0x180,0x1C0,0x200) → queue_count=4, drop_count=1. Raise ready → lines issued in order 0x100…0x1C0.
- DEDUP_EN: push 0x2000 then 0x2010 (same line) → one issue, drop_count=1. After it issues, push 0x2000 again → dropped (history hit), drop_count=2.
- Full queue with ready=1 and a new distinct candidate in the same cycle → accepted; queue_count stays 4; drop_count unchanged.
- pf_addr=0x0000003C (line 0) → no issue; drop_count unchanged.
- Reset asserted while queue_count=3 and a request is pending → next cycle dcache_req_valid=0, queue_count=0, drop_count=0.
